seven_seg_scanner: RTL and testbench



---
 rtl/seven_seg_scanner.sv | 154 +++++++++++++++
 tb/tb_seven_seg_scanner.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : seven_seg_scanner
// Brief    : Four-digit common-anode 7-segment scan driver with dead gap,
//            per-digit blanking and per-digit blinking.
// Revision : 1.0
// ============================================================================
module seven_seg_scanner #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [27:0] seg_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank_mask,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [1:0]  digit_idx,
    output logic        frame_tick
);

    localparam int c_REF_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
    localparam int c_FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_REF_W-1:0] c_REF_LAST = c_REF_W'(REFRESH_DIV - 1);
    localparam logic [c_REF_W-1:0] c_REF_ZERO = '0;
    localparam logic [c_REF_W-1:0] c_REF_ONE  = c_REF_W'(1);
    localparam logic [c_FRM_W-1:0] c_FRM_LAST = c_FRM_W'(BLINK_FRAMES - 1);
    localparam logic [c_FRM_W-1:0] c_FRM_ZERO = '0;
    localparam logic [c_FRM_W-1:0] c_FRM_ONE  = c_FRM_W'(1);

    localparam logic [3:0] c_AN_DARK  = 4'b1111;
    localparam logic [6:0] c_SEG_DARK = 7'b1111111;

    typedef enum logic [0:0] {
        ST_GAP   = 1'b0,
        ST_DRIVE = 1'b1
    } state_t;

    state_t              r_state_q,      w_state_d;
    logic [c_REF_W-1:0]  r_ref_cnt_q,    w_ref_cnt_d;
    logic [c_FRM_W-1:0]  r_frm_cnt_q,    w_frm_cnt_d;
    logic                r_phase_q,      w_phase_d;
    logic [1:0]          r_idx_q,        w_idx_d;
    logic [3:0]          r_an_q,         w_an_d;
    logic [6:0]          r_seg_q,        w_seg_d;
    logic                r_dp_q,         w_dp_d;
    logic                r_frame_tick_q, w_frame_tick_d;

    logic [6:0]          w_digit_seg;
    logic                w_digit_dark;
    logic [3:0]          w_digit_an;

    // Pattern and anode select for the slot about to be loaded.
    always_comb begin
        w_digit_seg = seg_in[6:0];
        case (r_idx_q)
            2'd0:    w_digit_seg = seg_in[6:0];
            2'd1:    w_digit_seg = seg_in[13:7];
            2'd2:    w_digit_seg = seg_in[20:14];
            default: w_digit_seg = seg_in[27:21];
        endcase
        w_digit_dark = blank_mask[r_idx_q] | (blink_mask[r_idx_q] & r_phase_q);
        w_digit_an   = ~(4'b0001 << r_idx_q);
    end

    always_comb begin
        w_state_d      = r_state_q;
        w_ref_cnt_d    = r_ref_cnt_q;
        w_frm_cnt_d    = r_frm_cnt_q;
        w_phase_d      = r_phase_q;
        w_idx_d        = r_idx_q;
        w_an_d         = r_an_q;
        w_seg_d        = r_seg_q;
        w_dp_d         = r_dp_q;
        w_frame_tick_d = 1'b0;

        if (!en) begin
            // Parked: blink state is kept so a resumed display stays in step.
            w_state_d   = ST_GAP;
            w_idx_d     = 2'd0;
            w_ref_cnt_d = c_REF_ZERO;
            w_an_d      = c_AN_DARK;
            w_seg_d     = c_SEG_DARK;
            w_dp_d      = 1'b1;
        end else begin
            case (r_state_q)
                ST_GAP: begin
                    w_state_d   = ST_DRIVE;
                    w_ref_cnt_d = c_REF_ZERO;
                    w_seg_d     = w_digit_seg;
                    w_dp_d      = ~dp_in[r_idx_q];
                    w_an_d      = w_digit_dark ? c_AN_DARK : w_digit_an;
                end
                default: begin
                    if (r_ref_cnt_q == c_REF_LAST) begin
                        w_state_d = ST_GAP;
                        w_idx_d   = r_idx_q + 2'd1;
                        w_an_d    = c_AN_DARK;
                        w_seg_d   = c_SEG_DARK;
                        w_dp_d    = 1'b1;
                        if (r_idx_q == 2'd3) begin
                            w_frame_tick_d = 1'b1;
                            if (r_frm_cnt_q == c_FRM_LAST) begin
                                w_frm_cnt_d = c_FRM_ZERO;
                                w_phase_d   = ~r_phase_q;
                            end else begin
                                w_frm_cnt_d = r_frm_cnt_q + c_FRM_ONE;
                            end
                        end
                    end else begin
                        w_ref_cnt_d = r_ref_cnt_q + c_REF_ONE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state_q      <= ST_GAP;
            r_ref_cnt_q    <= c_REF_ZERO;
            r_frm_cnt_q    <= c_FRM_ZERO;
            r_phase_q      <= 1'b0;
            r_idx_q        <= 2'd0;
            r_an_q         <= c_AN_DARK;
            r_seg_q        <= c_SEG_DARK;
            r_dp_q         <= 1'b1;
            r_frame_tick_q <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_ref_cnt_q    <= w_ref_cnt_d;
            r_frm_cnt_q    <= w_frm_cnt_d;
            r_phase_q      <= w_phase_d;
            r_idx_q        <= w_idx_d;
            r_an_q         <= w_an_d;
            r_seg_q        <= w_seg_d;
            r_dp_q         <= w_dp_d;
            r_frame_tick_q <= w_frame_tick_d;
        end
    end

    assign an         = r_an_q;
    assign seg        = r_seg_q;
    assign dp         = r_dp_q;
    assign digit_idx  = r_idx_q;
    assign frame_tick = r_frame_tick_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_seven_seg_scanner
// Brief    : Scoreboard bench for seven_seg_scanner (REFRESH_DIV=4, BLINK_FRAMES=2).
// Revision : 1.0
// ============================================================================
module tb_seven_seg_scanner;

    localparam int RD = 4;
    localparam int BF = 2;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic [1:0] idx;
        logic       tick;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b1;
    logic [27:0] seg_in = {7'h01, 7'h02, 7'h03, 7'h04};
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  blank_mask = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic [1:0]  digit_idx;
    logic        frame_tick;

    int   checks = 0;
    int   errors = 0;
    int   tb_frames = 0;
    exp_t exp_q[$];

    seven_seg_scanner #(
        .REFRESH_DIV  (RD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .seg_in     (seg_in),
        .dp_in      (dp_in),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .digit_idx  (digit_idx),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic push_entry(input logic [3:0] a, input logic [6:0] s, input logic d,
                              input logic [1:0] i, input logic t);
        exp_t e;
        e.an = a; e.seg = s; e.dp = d; e.idx = i; e.tick = t;
        exp_q.push_back(e);
    endtask

    task automatic push_dark();
        push_entry(4'hF, 7'h7F, 1'b1, 2'd0, 1'b0);
    endtask

    // Expected lit cycles of digit k using the inputs as they stand now.
    task automatic push_drive(input int k, input int cycles);
        logic       ph;
        logic [3:0] a;
        logic [27:0] s;
        ph = ((tb_frames / BF) % 2) == 1;
        a  = 4'b0001 << k;
        a  = ~a;
        if (blank_mask[k] || (blink_mask[k] && ph)) a = 4'hF;
        s = seg_in;
        repeat (cycles) push_entry(a, s[7*k +: 7], ~dp_in[k], 2'(k), 1'b0);
    endtask

    task automatic push_slot(input int k);
        push_drive(k, RD);
        push_entry(4'hF, 7'h7F, 1'b1, 2'((k + 1) % 4), k == 3);
        if (k == 3) tb_frames++;
    endtask

    task automatic push_frame();
        for (int k = 0; k < 4; k++) push_slot(k);
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (2) @(posedge clk);
        push_dark();
        push_dark();
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL reset: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                         an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
            end
        end
        rst_n = 1'b1;
        tb_frames = 0;
    endtask

    task automatic test_scan();
        exp_t e;
        int n = 0;
        push_frame();
        push_frame();
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL scan n=%0d: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                         n, an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
            end
            n++;
        end
    endtask

    task automatic test_no_tearing();
        exp_t e;
        int n = 0;
        push_frame();
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL tearing n=%0d: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                         n, an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
            end
            if (n == 6) begin
                seg_in[13:7] = 7'h55;
                dp_in        = 4'b0010;
            end
            n++;
        end
        push_frame();
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL tearing_next n=%0d: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                         n, an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
            end
            n++;
        end
    endtask

    task automatic test_blink();
        exp_t e;
        int n = 0;
        blink_mask = 4'b0100;
        dp_in      = 4'b0101;
        repeat (6) push_frame();
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL blink n=%0d: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                         n, an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
            end
            n++;
        end
    endtask

    task automatic test_blank();
        exp_t e;
        int n = 0;
        blank_mask = 4'b1000;
        blink_mask = 4'b1000;
        seg_in     = {7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom)};
        repeat (8) push_frame();
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL blank n=%0d: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                         n, an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
            end
            n++;
        end
    endtask

    task automatic test_enable();
        exp_t e;
        int n = 0;
        blank_mask = 4'b0000;
        blink_mask = 4'b0001;
        push_slot(0);
        push_slot(1);
        push_drive(2, 2);
        repeat (3) push_dark();
        push_frame();
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL enable n=%0d: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                         n, an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
            end
            if (n == 11) en = 1'b0;
            if (n == 14) en = 1'b1;
            n++;
        end
    endtask

    task automatic test_mid_reset();
        exp_t e;
        int n = 0;
        blink_mask = 4'b0001;
        // Reach a frame where the blink phase is 1.
        while (((tb_frames / BF) % 2) != 1) begin
            push_frame();
            while (exp_q.size() != 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                checks++;
                if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                    errors++;
                    $display("FAIL mid_reset_pre: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                             an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
                end
            end
        end
        push_slot(0);
        push_slot(1);
        push_slot(2);
        push_drive(3, 2);
        push_dark();
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL mid_reset n=%0d: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                         n, an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
            end
            if (n == 16) rst_n = 1'b0;
            if (n == 17) rst_n = 1'b1;
            n++;
        end
        tb_frames = 0;
        push_frame();
        push_frame();
        n = 0;
        while (exp_q.size() != 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if ({an, seg, dp, digit_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL after_reset n=%0d: got an=%b seg=%h dp=%b idx=%0d tick=%b, expected an=%b seg=%h dp=%b idx=%0d tick=%b",
                         n, an, seg, dp, digit_idx, frame_tick, e.an, e.seg, e.dp, e.idx, e.tick);
            end
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_scan();
        test_no_tearing();
        test_blink();
        test_blank();
        test_enable();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
